// File: rtl/id_stage_pkg.sv
// Shared decode constants and the control bundle for the ID stage; the EX/Wb bit
// positions are also used by the execute stage.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int EX_ALUSRC   = 0;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_REGDST   = 3;

  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;

  typedef struct packed {
    logic [3:0] ex;
    logic [1:0] wb;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.ex[EX_REGDST]                  = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_FUNCT;
        c.wb[WB_REGWRITE]                = 1'b1;
      end
      OP_LW: begin
        c.ex[EX_ALUSRC]                  = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_ADD;
        c.wb[WB_REGWRITE]                = 1'b1;
        c.wb[WB_MEMTOREG]                = 1'b1;
        c.mem_read                       = 1'b1;
      end
      OP_SW: begin
        c.ex[EX_ALUSRC]                  = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_ADD;
        c.mem_write                      = 1'b1;
      end
      OP_BEQ: begin
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_SUB;
      end
      OP_ADDI: begin
        c.ex[EX_ALUSRC]                  = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_ADD;
        c.wb[WB_REGWRITE]                = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 2-read / 1-write register file: r0 hardwired to zero, reads see a same-cycle
// writeback so WB and ID can share a cycle without a separate forwarding path.
module reg_file #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_reg [NREG];
  logic        wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_en && waddr == 5'(i)) regs_reg[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata1 = regs_reg[raddr1];
    rdata2 = regs_reg[raddr2];
    if (wr_en && waddr == raddr1) rdata1 = wdata;
    if (wr_en && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: control decode, register read, hazard
// detection, early beq resolution and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_dest,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] sign_extend,
  output logic [3:0]  EX,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [1:0]  Wb,
  output logic        MemR,
  output logic        MemW,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic [31:0] branch_target
);

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [31:0] rd1, rd2;
  ctrl_t       ctrl;
  logic        is_beq;
  logic [4:0]  idex_dest;
  logic        load_use, branch_stall, stall, branch_taken;

  logic [31:0] data1_reg, data2_reg, sext_reg;
  logic [3:0]  ex_reg;
  logic [1:0]  wb_reg;
  logic [4:0]  rs_reg, rt_reg, rd_reg;
  logic        memr_reg, memw_reg;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign ctrl     = decode(opcode);
  assign is_beq   = (opcode == OP_BEQ);

  reg_file #(.NREG(NREG)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rd1),
    .rdata2 (rd2),
    .we     (wb_reg_write),
    .waddr  (wb_dest),
    .wdata  (wb_data)
  );

  // Hazards are judged against our own registered ID/EX fields.
  assign idex_dest = ex_reg[EX_REGDST] ? rd_reg : rt_reg;
  assign load_use  = memr_reg && (rt_reg == rs || rt_reg == rt);

  assign branch_stall = is_beq &&
    ((wb_reg[WB_REGWRITE] && idex_dest != 5'd0 && (idex_dest == rs || idex_dest == rt)) ||
     (mem_reg_write && mem_dest != 5'd0 && (mem_dest == rs || mem_dest == rt)));

  assign stall        = load_use || branch_stall;
  assign branch_taken = is_beq && !stall && (rd1 == rd2);

  assign pc_write      = rst || !stall;
  assign ifid_write    = rst || !stall;
  assign ifid_flush    = !rst && branch_taken;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst || stall) begin
      data1_reg <= '0;
      data2_reg <= '0;
      sext_reg  <= '0;
      ex_reg    <= '0;
      wb_reg    <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      rd_reg    <= '0;
      memr_reg  <= 1'b0;
      memw_reg  <= 1'b0;
    end else begin
      data1_reg <= rd1;
      data2_reg <= rd2;
      sext_reg  <= imm_sext;
      ex_reg    <= ctrl.ex;
      wb_reg    <= ctrl.wb;
      rs_reg    <= rs;
      rt_reg    <= rt;
      rd_reg    <= rd;
      memr_reg  <= ctrl.mem_read;
      memw_reg  <= ctrl.mem_write;
    end
  end

  assign data1       = data1_reg;
  assign data2       = data2_reg;
  assign sign_extend = sext_reg;
  assign EX          = ex_reg;
  assign Wb          = wb_reg;
  assign Rs          = rs_reg;
  assign Rt          = rt_reg;
  assign Rd          = rd_reg;
  assign MemR        = memr_reg;
  assign MemW        = memw_reg;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: hand-computed expectations for decode,
// bypass, load-use and branch hazards, early beq and reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc_plus4, wb_data;
  logic        wb_reg_write, mem_reg_write;
  logic [4:0]  wb_dest, mem_dest;
  logic [31:0] data1, data2, sign_extend, branch_target;
  logic [3:0]  EX;
  logic [4:0]  Rs, Rt, Rd;
  logic [1:0]  Wb;
  logic        MemR, MemW, pc_write, ifid_write, ifid_flush;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] I_NOP = 32'hFC00_0000;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_plus4(pc_plus4),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .data1(data1), .data2(data2), .sign_extend(sign_extend), .EX(EX),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Wb(Wb), .MemR(MemR), .MemW(MemW),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .branch_target(branch_target)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance one clock edge, then settle so comb and registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = I_NOP; pc_plus4 = 32'h0;
    wb_reg_write = 1'b0; wb_dest = 5'd0; wb_data = 32'h0;
    mem_reg_write = 1'b0; mem_dest = 5'd0;
    step();
    step();
    settle();
    check("rst_pc_write", 32'(pc_write), 32'h1);
    check("rst_ifid_flush", 32'(ifid_flush), 32'h0);
    check("rst_EX", 32'(EX), 32'h0);
    check("rst_Wb", 32'(Wb), 32'h0);
    check("rst_data1", data1, 32'h0);

    // Write-through bypass: r5 written by WB while read in ID.
    rst = 1'b0;
    wb_reg_write = 1'b1; wb_dest = 5'd5; wb_data = 32'h0000_1234;
    instr = 32'h00A0_3020;  // add r6,r5,r0
    step();
    check("bypass_data1", data1, 32'h0000_1234);
    check("bypass_Rs", 32'(Rs), 32'd5);
    check("rtype_EX", 32'(EX), 32'hC);
    check("rtype_Wb", 32'(Wb), 32'h2);
    check("rtype_Rd", 32'(Rd), 32'd6);

    // WB to r0 is ignored, even for the bypass.
    wb_dest = 5'd0; wb_data = 32'h0000_DEAD;
    instr = 32'h0005_3020;  // add r6,r0,r5
    step();
    check("r0_bypass_data1", data1, 32'h0);
    check("r5_stored_data2", data2, 32'h0000_1234);
    wb_reg_write = 1'b0;
    step();
    check("r0_after_write", data1, 32'h0);

    // Preload r1 = 0x11 while ID sits idle.
    wb_reg_write = 1'b1; wb_dest = 5'd1; wb_data = 32'h0000_0011;
    instr = I_NOP;
    step();
    wb_reg_write = 1'b0;

    // Load-use: lw r2,4(r1) ; add r3,r2,r4
    instr = 32'h8C22_0004;
    step();
    check("lw_MemR", 32'(MemR), 32'h1);
    check("lw_Wb", 32'(Wb), 32'h3);
    check("lw_EX", 32'(EX), 32'h1);
    check("lw_sext", sign_extend, 32'h4);
    check("lw_data1", data1, 32'h11);
    instr = 32'h0044_1820;
    settle();
    check("lu_pc_write", 32'(pc_write), 32'h0);
    check("lu_ifid_write", 32'(ifid_write), 32'h0);
    step();
    check("lu_bubble_Wb", 32'(Wb), 32'h0);
    check("lu_bubble_MemR", 32'(MemR), 32'h0);
    check("lu_bubble_EX", 32'(EX), 32'h0);
    check("lu_release_pc_write", 32'(pc_write), 32'h1);
    step();
    check("lu_add_EX", 32'(EX), 32'hC);
    check("lu_add_Rd", 32'(Rd), 32'd3);

    // Taken branch: beq r1,r1,+3 at pc_plus4=0x100.
    instr = 32'h1021_0003; pc_plus4 = 32'h0000_0100;
    settle();
    check("beq_target", branch_target, 32'h0000_010C);
    check("beq_flush", 32'(ifid_flush), 32'h1);
    check("beq_pc_write", 32'(pc_write), 32'h1);
    step();
    check("beq_EX", 32'(EX), 32'h2);
    check("beq_Wb", 32'(Wb), 32'h0);
    check("beq_sext", sign_extend, 32'h3);

    // Negative offset: beq r0,r0,-1.
    instr = 32'h1000_FFFF;
    settle();
    check("beq_neg_target", branch_target, 32'h0000_00FC);
    check("beq_neg_flush", 32'(ifid_flush), 32'h1);
    step();
    instr = I_NOP;
    settle();
    check("nop_flush", 32'(ifid_flush), 32'h0);
    step();

    // Branch hazard: addi r7,r0,5 ; beq r7,r0,+2.
    instr = 32'h2007_0005;
    step();
    check("addi_EX", 32'(EX), 32'h1);
    check("addi_Wb", 32'(Wb), 32'h2);
    check("addi_Rt", 32'(Rt), 32'd7);
    instr = 32'h10E0_0002;
    settle();
    check("bh_stall1_pc_write", 32'(pc_write), 32'h0);
    check("bh_stall1_flush", 32'(ifid_flush), 32'h0);
    step();
    check("bh_bubble_EX", 32'(EX), 32'h0);
    mem_reg_write = 1'b1; mem_dest = 5'd7;
    settle();
    check("bh_stall2_pc_write", 32'(pc_write), 32'h0);
    step();
    mem_reg_write = 1'b0; mem_dest = 5'd0;
    wb_reg_write = 1'b1; wb_dest = 5'd7; wb_data = 32'h5;
    settle();
    check("bh_release_pc_write", 32'(pc_write), 32'h1);
    check("bh_not_taken_flush", 32'(ifid_flush), 32'h0);
    step();
    wb_reg_write = 1'b0;
    check("bh_beq_EX", 32'(EX), 32'h2);
    check("bh_beq_data1", data1, 32'h5);

    // Stall beats equal operands: beq r1,r1 with r1 pending in EX/MEM.
    instr = I_NOP;
    step();
    instr = 32'h1021_0003; mem_reg_write = 1'b1; mem_dest = 5'd1;
    settle();
    check("sw_stall_pc_write", 32'(pc_write), 32'h0);
    check("sw_stall_flush", 32'(ifid_flush), 32'h0);
    step();
    mem_reg_write = 1'b0; mem_dest = 5'd0;

    // sw r4,8(r1)
    instr = 32'hAC24_0008;
    step();
    check("sw_MemW", 32'(MemW), 32'h1);
    check("sw_Wb", 32'(Wb), 32'h0);
    check("sw_EX", 32'(EX), 32'h1);

    // Reset during a load-use stall.
    instr = 32'h8C22_0004;
    step();
    instr = 32'h0044_1820;
    settle();
    check("rs_stall_active", 32'(pc_write), 32'h0);
    rst = 1'b1;
    settle();
    check("rs_pc_write", 32'(pc_write), 32'h1);
    check("rs_ifid_write", 32'(ifid_write), 32'h1);
    check("rs_flush", 32'(ifid_flush), 32'h0);
    step();
    check("rs_EX", 32'(EX), 32'h0);
    check("rs_Wb", 32'(Wb), 32'h0);
    check("rs_MemR", 32'(MemR), 32'h0);
    check("rs_data1", data1, 32'h0);
    rst = 1'b0;
    instr = 32'h00A1_3020;  // add r6,r5,r1
    settle();
    check("rs_after_pc_write", 32'(pc_write), 32'h1);
    step();
    check("rs_r5_cleared", data1, 32'h0);
    check("rs_r1_cleared", data2, 32'h0);

    // Unknown opcode 111111 decodes as NOP and never stalls.
    instr = 32'hFC22_1234;
    settle();
    check("unk_pc_write", 32'(pc_write), 32'h1);
    step();
    check("unk_EX", 32'(EX), 32'h0);
    check("unk_Wb", 32'(Wb), 32'h0);
    check("unk_MemR", 32'(MemR), 32'h0);
    check("unk_MemW", 32'(MemW), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage 32-bit MIPS pipeline, sitting between the IF/ID register and the execute stage. It decodes the opcode into control fields, reads the 32x32 register file, sign-extends the immediate, detects load-use and branch hazards, resolves `beq` early, and holds the ID/EX pipeline register that feeds the execute stage directly. Writeback from the end of the pipeline enters here through the register-file write port.

## Interface
Parameters:
- `NREG`, 32: register-file depth. Index width is fixed at 5.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction from IF/ID.
- `pc_plus4`  in  32  PC+4 from IF/ID.
- `wb_reg_write`  in  1  writeback write enable.
- `wb_dest`  in  5  writeback register index.
- `wb_data`  in  32  writeback data.
- `mem_reg_write`, `mem_dest`  in  1/5  RegWrite and destination of the instruction in EX/MEM; used only for the branch hazard.
- `data1`, `data2`  out  32  registered rs and rt values.
- `sign_extend`  out  32  registered sign-extended imm16. Bits [5:0] carry funct.
- `EX`  out  4  registered: [0] ALUSrc, [2:1] ALUOp, [3] RegDst.
- `Rs`, `Rt`, `Rd`  out  5  registered register indices.
- `Wb`  out  2  registered: [1] RegWrite, [0] MemtoReg.
- `MemR`, `MemW`  out  1  registered memory read and memory write.
- `pc_write`, `ifid_write`  out  1  combinational. 0 holds the PC and IF/ID.
- `ifid_flush`  out  1  combinational. 1 loads a NOP into IF/ID.
- `branch_target`  out  32  combinational: `pc_plus4 + (sext(imm16) << 2)`.

## Operation
- Decode by opcode `instr[31:26]`:
  - R-type `000000`: RegDst=1, ALUOp=10, RegWrite=1.
  - lw `100011`: ALUSrc=1, ALUOp=00, RegWrite=1, MemtoReg=1, MemR=1.
  - sw `101011`: ALUSrc=1, ALUOp=00, MemW=1.
  - beq `000100`: ALUOp=01. No writes.
  - addi `001000`: ALUSrc=1, ALUOp=00, RegWrite=1.
  - Any other opcode: all controls 0 (NOP).
- Register file:
  - r0 always reads 0. Writes to r0 are ignored.
  - A write occurs at the clock edge when `wb_reg_write && wb_dest != 0`.
  - Write-through bypass: a same-cycle read of `wb_dest` (non-zero, `wb_reg_write`=1) returns `wb_data`.
- Load-use stall: `MemR && (Rt == instr[25:21] || Rt == instr[20:16])`, using this block's own ID/EX outputs.
- Branch stall (beq only): asserted if either condition matches rs or rt of the beq, with a non-zero index:
  - ID/EX destination: `Wb[1]` and destination `EX[3] ? Rd : Rt`.
  - EX/MEM destination: `mem_reg_write` and `mem_dest`.
- `stall` is the OR of both stalls. When `stall`=1:
  - `pc_write` = 0 and `ifid_write` = 0.
  - The ID/EX register loads a bubble: all control fields 0. Data and index fields are don't-care, but are loaded as 0.
- Branch taken: `branch_taken` = beq && !stall && (rs value == rt value), with both values taken after the bypass.
  - `ifid_flush` = `branch_taken`.
  - The beq itself still enters ID/EX with ALUOp=01.
- Simultaneous stall and equal operands: the stall wins and no flush occurs. The branch re-evaluates on the next cycle.

## Timing
- Register-file read and decode are combinational.
- ID/EX latency is one cycle: values present at edge n appear on the outputs after edge n.
- A load-use stall lasts exactly 1 cycle.
- A branch stall lasts 1–2 cycles; it persists until the producing instruction reaches WB.
- Reset:
  - All ID/EX outputs are 0.
  - All 32 registers are cleared to 0.
  - Reset overrides a stall or writeback in the same cycle.
  - `pc_write`/`ifid_write` are 1 and `ifid_flush` is 0 while `rst`=1.

## Structure
- Shared package holds:
  - Opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`).
  - ALUOp encodings (`ALUOP_ADD`=00, `ALUOP_SUB`=01, `ALUOP_FUNCT`=10).
  - EX and Wb bit-index constants, shared with the execute stage.
- One natural sub-module: `reg_file`, 2 read ports, 1 write port, r0 hardwired, write-through bypass.
- Decode, hazard detection and the ID/EX register stay in `id_stage`.

## Test plan
- Write-through bypass: reg write r5=0x1234 via WB while the ID instruction reads r5 in the same cycle -> `data1`=0x1234 after the edge. A WB write to r0 is ignored: r0 still reads 0.
- Load-use stall: `lw r2,4(r1)` followed by `add r3,r2,r4` -> 1 cycle of `pc_write`=`ifid_write`=0, bubble in ID/EX (`Wb`=0, `MemR`=0). The add issues on the next cycle.
- Taken branch: `beq r1,r1,+3` with `pc_plus4`=0x100 -> `branch_target`=0x10C and `ifid_flush`=1 for 1 cycle; ID/EX gets `EX`=4'b0010.
- Branch hazard: `addi r7,r0,5` followed by `beq r7,r0` -> stall for 2 cycles, then the branch resolves as not taken.
- Reset mid-stall: assert `rst` while a load-use stall is active -> all outputs 0 next cycle, `pc_write`=1, all registers read 0.
- Unknown opcode `111111` -> all ID/EX control fields 0 and no stall.
